// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: master FSM state encoding and response codes.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_chan_hold.sv
// One AXI request channel: VALID plus payload, loaded on command accept and
// held until the slave's READY is sampled high.
module axi4_lite_chan_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4_lite_master_fsm.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI
// read or write transaction and returns the slave's response.
module axi4_lite_master_fsm
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_write,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);

  localparam int STRB_W = DATA_W / 8;

  state_t state, state_nxt;
  logic   cmd_acc, aw_ok, w_ok;
  logic   cmd_ready_d, bready_d, rready_d, rsp_valid_d;
  logic [STRB_W+DATA_W-1:0] w_hold;

  assign AWPROT  = 3'b000;
  assign ARPROT  = 3'b000;
  assign cmd_acc = cmd_valid && cmd_ready;
  // A write channel counts as done once its VALID has already dropped or is handshaking now.
  assign aw_ok   = !AWVALID || AWREADY;
  assign w_ok    = !WVALID || WREADY;
  assign {WSTRB, WDATA} = w_hold;

  axi4_lite_chan_hold #(.DATA_W(ADDR_W)) u_aw (
    .clk(clk), .rst(rst), .load(cmd_acc && cmd_write), .load_data(cmd_addr),
    .ready(AWREADY), .valid(AWVALID), .data(AWADDR)
  );

  axi4_lite_chan_hold #(.DATA_W(STRB_W + DATA_W)) u_w (
    .clk(clk), .rst(rst), .load(cmd_acc && cmd_write), .load_data({cmd_wstrb, cmd_wdata}),
    .ready(WREADY), .valid(WVALID), .data(w_hold)
  );

  axi4_lite_chan_hold #(.DATA_W(ADDR_W)) u_ar (
    .clk(clk), .rst(rst), .load(cmd_acc && !cmd_write), .load_data(cmd_addr),
    .ready(ARREADY), .valid(ARVALID), .data(ARADDR)
  );

  // State and registered handshake outputs; cmd_ready stays low while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      BREADY    <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= cmd_ready_d;
      BREADY    <= bready_d;
      RREADY    <= rready_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (cmd_acc) state_nxt = cmd_write ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (aw_ok && w_ok) state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (BVALID && BREADY) state_nxt = ST_RSP;
      ST_RD_REQ:  if (ARREADY) state_nxt = ST_RD_RESP;
      ST_RD_RESP: if (RVALID && RREADY) state_nxt = ST_RSP;
      ST_RSP:     if (rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_nxt == ST_IDLE);
    bready_d    = (state_nxt == ST_WR_RESP);
    rready_d    = (state_nxt == ST_RD_RESP);
    rsp_valid_d = (state_nxt == ST_RSP);
  end

  // Response capture only while the matching READY is being offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
      rsp_write <= 1'b0;
    end else if (state == ST_WR_RESP && BVALID) begin
      rsp_rdata <= '0;
      rsp_resp  <= BRESP;
      rsp_write <= 1'b1;
    end else if (state == ST_RD_RESP && RVALID) begin
      rsp_rdata <= RDATA;
      rsp_resp  <= RRESP;
      rsp_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_fsm.sv
// Scoreboard bench for axi4_lite_master_fsm with a scripted/randomized AXI slave.
module tb_axi4_lite_master_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic [1:0]  BRESP, RRESP;

  axi4_lite_master_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial forever #5 clk = ~clk;

  // One transaction: command fields, slave's answer, and per-channel READY delays.
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          aw_d, w_d, ar_d, b_d, r_d, rsp_d;
  } plan_t;

  plan_t exp_q[$];
  plan_t sl_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  spurious = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic plan_t mk(logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] st,
                               logic [1:0] rs, logic [31:0] rd, int awd, int wdl, int ard,
                               int bd, int rdl, int rspd);
    plan_t p;
    p.write = w; p.addr = a; p.wdata = wd; p.wstrb = st; p.resp = rs; p.rdata = rd;
    p.aw_d = awd; p.w_d = wdl; p.ar_d = ard; p.b_d = bd; p.r_d = rdl; p.rsp_d = rspd;
    return p;
  endfunction

  // ---------------- slave model ----------------
  int          awcnt, wcnt, arcnt, bcnt, rcnt, brdy_cnt, rrdy_cnt;
  logic        aw_done, w_done, ar_done, both_p, ar_p;
  logic        aw_hs_p, w_hs_p, ar_hs_p, awv_p, wv_p, arv_p;
  logic [31:0] awaddr_p, araddr_p;
  logic [35:0] w_p;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      BRESP = 0; RRESP = 0; RDATA = 0;
      awcnt = 0; wcnt = 0; arcnt = 0; bcnt = 0; rcnt = 0; brdy_cnt = 0; rrdy_cnt = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
      aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; awv_p = 0; wv_p = 0; arv_p = 0;
    end else begin
      both_p = aw_done && w_done;
      ar_p   = ar_done;
      // AW channel
      if (aw_hs_p) chk("awvalid_drop", 64'(AWVALID), 64'd0);
      else if (awv_p) chk("aw_hold", 64'({AWVALID, AWADDR}), 64'({1'b1, awaddr_p}));
      AWREADY = 0;
      if (AWVALID) begin
        if (sl_q.size() == 0 || !sl_q[0].write || aw_done) chk("aw_unexpected", 64'(AWVALID), 64'd0);
        else begin AWREADY = (awcnt >= sl_q[0].aw_d); awcnt++; end
      end
      aw_hs_p = AWVALID && AWREADY;
      if (aw_hs_p) begin
        chk("aw_addr", 64'(AWADDR), 64'(sl_q[0].addr));
        chk("aw_cycles", 64'(awcnt), 64'(sl_q[0].aw_d + 1));
        chk("awprot", 64'(AWPROT), 64'd0);
        aw_done = 1; awcnt = 0;
      end
      awv_p = AWVALID; awaddr_p = AWADDR;
      // W channel
      if (w_hs_p) chk("wvalid_drop", 64'(WVALID), 64'd0);
      else if (wv_p) chk("w_hold", 64'({WVALID, WSTRB, WDATA}), 64'({1'b1, w_p}));
      WREADY = 0;
      if (WVALID) begin
        if (sl_q.size() == 0 || !sl_q[0].write || w_done) chk("w_unexpected", 64'(WVALID), 64'd0);
        else begin WREADY = (wcnt >= sl_q[0].w_d); wcnt++; end
      end
      w_hs_p = WVALID && WREADY;
      if (w_hs_p) begin
        chk("w_payload", 64'({WSTRB, WDATA}), 64'({sl_q[0].wstrb, sl_q[0].wdata}));
        chk("w_cycles", 64'(wcnt), 64'(sl_q[0].w_d + 1));
        w_done = 1; wcnt = 0;
      end
      wv_p = WVALID; w_p = {WSTRB, WDATA};
      // AR channel
      if (ar_hs_p) chk("arvalid_drop", 64'(ARVALID), 64'd0);
      else if (arv_p) chk("ar_hold", 64'({ARVALID, ARADDR}), 64'({1'b1, araddr_p}));
      ARREADY = 0;
      if (ARVALID) begin
        if (sl_q.size() == 0 || sl_q[0].write || ar_done) chk("ar_unexpected", 64'(ARVALID), 64'd0);
        else begin ARREADY = (arcnt >= sl_q[0].ar_d); arcnt++; end
      end
      ar_hs_p = ARVALID && ARREADY;
      if (ar_hs_p) begin
        chk("ar_addr", 64'(ARADDR), 64'(sl_q[0].addr));
        chk("ar_cycles", 64'(arcnt), 64'(sl_q[0].ar_d + 1));
        chk("arprot", 64'(ARPROT), 64'd0);
        ar_done = 1; arcnt = 0;
      end
      arv_p = ARVALID; araddr_p = ARADDR;
      // B channel: answers b_d cycles after both AW and W completed
      BVALID = 0; BRESP = 2'($urandom);
      if (BREADY && !both_p) chk("bready_early", 64'(BREADY), 64'd0);
      if (both_p) begin
        if (BREADY) brdy_cnt++;
        if (bcnt >= sl_q[0].b_d) begin BVALID = 1; BRESP = sl_q[0].resp; end
        bcnt++;
        if (BVALID && BREADY) begin
          chk("bready_cycles", 64'(brdy_cnt), 64'(sl_q[0].b_d + 1));
          void'(sl_q.pop_front());
          aw_done = 0; w_done = 0; bcnt = 0; brdy_cnt = 0;
        end
      end else if (spurious) BVALID = 1;
      // R channel
      RVALID = 0; RRESP = 2'($urandom); RDATA = $urandom;
      if (RREADY && !ar_p) chk("rready_early", 64'(RREADY), 64'd0);
      if (ar_p) begin
        if (RREADY) rrdy_cnt++;
        if (rcnt >= sl_q[0].r_d) begin RVALID = 1; RRESP = sl_q[0].resp; RDATA = sl_q[0].rdata; end
        rcnt++;
        if (RVALID && RREADY) begin
          chk("rready_cycles", 64'(rrdy_cnt), 64'(sl_q[0].r_d + 1));
          void'(sl_q.pop_front());
          ar_done = 0; rcnt = 0; rrdy_cnt = 0;
        end
      end else if (spurious) RVALID = 1;
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  int          rspcnt;
  logic        rsp_hs_p, rspv_p;
  logic [34:0] rsp_p;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rsp_ready = 0; rspcnt = 0; rsp_hs_p = 0; rspv_p = 0; rsp_p = '0;
    end else begin
      if (rsp_hs_p) begin
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
      end else if (rspv_p) begin
        chk("rsp_hold", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({1'b1, rsp_p}));
      end
      rsp_ready = 0;
      if (rsp_valid) begin
        chk("cmd_ready_in_rsp", 64'(cmd_ready), 64'd0);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
          rsp_ready = 1;
        end else begin
          rsp_ready = (rspcnt >= exp_q[0].rsp_d);
          rspcnt++;
          if (rsp_ready) begin
            chk("rsp_write", 64'(rsp_write), 64'(exp_q[0].write));
            chk("rsp_resp", 64'(rsp_resp), 64'(exp_q[0].resp));
            chk("rsp_rdata", 64'(rsp_rdata), exp_q[0].write ? 64'd0 : 64'(exp_q[0].rdata));
            void'(exp_q.pop_front());
            rspcnt = 0;
          end
        end
      end
      rsp_hs_p = rsp_valid && rsp_ready;
      rspv_p   = rsp_valid;
      rsp_p    = {rsp_write, rsp_resp, rsp_rdata};
    end
  end

  // ---------------- stimulus ----------------
  task automatic stop_fatal(string name);
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input plan_t p);
    int n = 0;
    cmd_valid = 1; cmd_write = p.write; cmd_addr = p.addr;
    cmd_wdata = p.wdata; cmd_wstrb = p.wstrb;
    while (!cmd_ready) begin
      @(negedge clk);
      n++;
      if (n > 2000) stop_fatal("cmd_accept");
    end
    exp_q.push_back(p);
    sl_q.push_back(p);
    @(negedge clk);
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || sl_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 2000) stop_fatal("drain");
    end
    @(negedge clk);
  endtask

  initial begin
    plan_t p;
    int    n;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_write}), 64'd0);
    chk("reset_payloads", 64'({AWADDR, ARADDR}), 64'd0);
    chk("reset_wdata", 64'({WSTRB, WDATA}), 64'd0);
    chk("reset_rsp", 64'({rsp_resp, rsp_rdata}), 64'd0);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("cmd_ready_post_reset", 64'(cmd_ready), 64'd1);

    // single-cycle write handshakes, OKAY
    issue(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    drain();
    // WREADY three cycles after AWREADY
    issue(mk(1, 32'h44, 32'hCAFEF00D, 4'h5, 2'b00, 0, 0, 3, 0, 1, 0, 0));
    drain();
    // delayed ARREADY, SLVERR read
    issue(mk(0, 32'h20, 0, 0, 2'b10, 32'h12345678, 0, 0, 2, 0, 1, 0));
    drain();
    // response back-pressure
    issue(mk(1, 32'h80, 32'h0BADF00D, 4'h3, 2'b11, 0, 1, 0, 0, 2, 0, 4));
    issue(mk(0, 32'h84, 0, 0, 2'b01, 32'hA5A5_5A5A, 0, 0, 0, 0, 3, 4));
    drain();

    // randomized back-to-back traffic
    for (int i = 0; i < 120; i++) begin
      p = mk(1'($urandom), $urandom, $urandom, 4'($urandom), 2'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      issue(p);
    end
    drain();

    // reset while waiting for the write response
    issue(mk(1, 32'hC0, 32'h11223344, 4'hF, 2'b00, 0, 0, 0, 0, 40, 0, 0));
    n = 0;
    while (!BREADY) begin
      @(negedge clk);
      n++;
      if (n > 50) stop_fatal("bready_wait");
    end
    #2 rst = 1;
    #1;
    chk("midrst_outputs", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    exp_q.delete();
    sl_q.delete();
    repeat (2) @(negedge clk);
    chk("midrst_cmd_ready_held", 64'(cmd_ready), 64'd0);
    #2 rst = 0;
    @(negedge clk);
    chk("cmd_ready_post_midrst", 64'(cmd_ready), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'({rsp_valid, BREADY, RREADY}), 64'd0);
    end

    // spurious B/R pulses while idle
    spurious = 1;
    repeat (5) begin
      @(negedge clk);
      chk("spurious_idle", 64'({cmd_ready, rsp_valid, BREADY, RREADY}), 64'b1000);
    end
    spurious = 0;
    @(negedge clk);
    issue(mk(0, 32'h30, 0, 0, 2'b00, 32'h0F0F_1234, 0, 0, 1, 0, 2, 1));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
